yarp_data_mem_resp: RTL and testbench
=====================================

Name: yarp_data_mem_resp

Overview:
- Responder (memory side) for the core's data memory interface: accepts req/addr/byte_en/wr/wr_data and returns read data.
- Holds an internal word-organised SRAM, enforces size and alignment rules, and inserts a programmable number of wait states.
- Adds a response-valid/busy/error handshake so the core and testbenches can run against realistic memory latency.
- Sits outside the core as the data memory model used in simulation and FPGA bring-up.

Parameters:
- MEM_DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_2000, byte address of word 0; must be 4-byte aligned.
- WAIT_CYCLES, 1, wait states between accept and response; legal range 0..7.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_mem_req_i  input  1  request strobe from core.
- data_mem_addr_i  input  32  byte address.
- data_mem_byte_en_i  input  2  access size: 2'b00 byte, 2'b01 half, 2'b11 word, 2'b10 reserved.
- data_mem_wr_i  input  1  1 = write, 0 = read.
- data_mem_wr_data_i  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- data_mem_rd_data_o  output  32  read data, right-justified, upper bits zero.
- data_mem_rsp_valid_o  output  1  one-cycle pulse marking a completed access.
- data_mem_busy_o  output  1  high while a request is in flight or the optional clear runs.
- data_mem_err_o  output  1  error flag for the current response; qualified by rsp_valid.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
- Reset (synchronous):
  - FSM goes to IDLE; wait counter clears.
  - rd_data_o = 0; rsp_valid_o, busy_o and err_o all 0.
  - Array contents are not reset unless the optional feature is compiled in.
- FSM states: IDLE, WAIT, RESP (plus CLEAR, only with the optional feature).
- Accept:
  - A request is accepted on a clock edge where req_i = 1 and the state is IDLE or RESP.
  - addr, byte_en, wr and wr_data are captured into request registers.
  - A request presented while in WAIT is ignored, not queued. The core must hold req until it sees rsp_valid.
- After accept:
  - WAIT_CYCLES = 0: go directly to RESP.
  - Otherwise: go to WAIT with the counter loaded to WAIT_CYCLES-1. Decrement each cycle; go to RESP when the counter reaches 0.
- Latency: rsp_valid_o is high exactly WAIT_CYCLES+1 cycles after the accept edge, for one cycle.
- Leaving RESP: go to IDLE, or accept a new request when req_i = 1. Peak throughput is one access per WAIT_CYCLES+1 cycles.
- busy_o: high in WAIT and CLEAR; low in IDLE and RESP.
- Array update and read capture:
  - Both happen on the edge that enters RESP.
  - Writes update only the addressed lanes. The byte goes to lane addr[1:0]; the half goes to lanes {addr[1],0}+1..0.
  - Reads return the addressed lanes shifted to bit 0, with upper bits zeroed (no sign extension; the core extends).
  - A write response returns rd_data_o = 0.
  - Read-after-write in consecutive requests returns the new data.
- Error conditions (err_o = 1 in RESP, no array write, rd_data_o = 0):
  - Address below BASE_ADDR, or at/above BASE_ADDR + 4*MEM_DEPTH_WORDS.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - byte_en = 2'b10.
- Indexing: word index = (addr - BASE_ADDR) >> 2. No wrap-around; out-of-range addresses never alias into the array.
- Output hold:
  - rd_data_o holds the last response value until the next RESP.
  - err_o is 0 outside RESP.
- Reset mid-operation: the pending request is dropped. A write still in WAIT is never committed, and no rsp_valid is issued for it.

Optional Feature:
- Macro: YARP_DMEM_ZERO_INIT_EN.
- Defined:
  - Reset enters CLEAR instead of IDLE.
  - CLEAR writes zero to one word per cycle, index 0 up to MEM_DEPTH_WORDS-1, with busy_o = 1 and requests ignored.
  - After the last word, go to IDLE. The first request can be accepted exactly MEM_DEPTH_WORDS cycles after reset deasserts.
  - Reset re-asserted during CLEAR restarts the clear at index 0.
- Not defined:
  - No CLEAR state; reset goes to IDLE.
  - Array contents are undefined at power-up and retained across reset.

Test Plan:
- Word write, WAIT_CYCLES=1: addr 0x2004, data 0xDEADBEEF, accepted at cycle 0 -> rsp_valid at cycle 2, err 0. Then word read 0x2004 -> rd_data 0xDEADBEEF.
- Byte write 0x2005 data 0x000000AA, then word read 0x2004 -> 0xDEADAAEF. Byte read 0x2007 -> 0x000000DE.
- Half read 0x2006 -> 0x0000DEAD. Half read 0x2005 -> err 1, rd_data 0. Word read 0x2006 -> err 1.
- Word read 0x1FFC and 0x3000 -> err 1. Word write 0x3000 value 0x12345678, then read 0x2000 -> unchanged (no alias).
- req_i held high for 3 word reads, WAIT_CYCLES=1:
  - rsp_valid pulses every 2 cycles; busy high in each WAIT.
  - WAIT_CYCLES=0: rsp_valid every cycle.
- Reset during WAIT of a write 0x55555555 to 0x2004 -> no rsp_valid, and a later read returns the prior value. With YARP_DMEM_ZERO_INIT_EN:
  - busy high for 1024 cycles after reset;
  - then a read of 0x2004 returns 0.

Source files
------------

// File: rtl/yarp_data_mem_resp.sv
// yarp_data_mem_resp: memory-side responder for the core's data memory port.
// Word-organised SRAM with size/alignment checking, a programmable number of
// wait states and a one-cycle response-valid pulse.
// Optional feature macro: YARP_DMEM_ZERO_INIT_EN (zero the array after reset).
//
// state   | meaning
// S_IDLE  | no request in flight, ready to accept
// S_WAIT  | request captured, counting down wait states
// S_RESP  | response presented (rsp_valid), may accept the next request
// S_CLEAR | post-reset array zeroing, one word per cycle (optional)
module yarp_data_mem_resp #(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
    parameter int          WAIT_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic [31:0] data_mem_rd_data_o,
    output logic        data_mem_rsp_valid_o,
    output logic        data_mem_busy_o,
    output logic        data_mem_err_o
);

    localparam int          LP_IDX_W     = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [32:0] LP_SPAN      = 33'(MEM_DEPTH_WORDS) * 33'd4;
    localparam logic [2:0]  LP_WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam state_t LP_ACC_STATE = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_mem [MEM_DEPTH_WORDS];
    logic [31:0]         r_addr;
    logic [1:0]          r_byte_en;
    logic                r_wr;
    logic [31:0]         r_wr_data;
    logic [2:0]          r_wait_cnt;
    logic [31:0]         r_rd_data;
    logic                r_err;

    logic                w_accept;
    logic                w_enter_resp;
    logic [31:0]         w_cur_addr;
    logic [1:0]          w_cur_byte_en;
    logic                w_cur_wr;
    logic [31:0]         w_cur_wr_data;
    logic [31:0]         w_off;
    logic                w_in_range;
    logic [1:0]          w_lane;
    logic [LP_IDX_W-1:0] w_idx;
    logic                w_size_err;
    logic                w_err;
    logic [3:0]          w_lane_mask;
    logic [31:0]         w_wr_word;
    logic [31:0]         w_rd_shift;
    logic [31:0]         w_rd_val;
    logic                w_mem_we;
    logic                w_clr_we;
    logic [LP_IDX_W-1:0] w_clr_idx;
    logic                w_clr_done;

    assign w_accept     = data_mem_req_i && ((r_state == S_IDLE) || (r_state == S_RESP));
    assign w_enter_resp = ((r_state == S_WAIT) && (r_wait_cnt == 3'd0)) ||
                          (w_accept && (WAIT_CYCLES == 0));

    // With no wait states RESP is entered on the accept edge itself, so the
    // live inputs are used; otherwise the captured request is used.
    assign w_cur_addr    = (WAIT_CYCLES == 0) ? data_mem_addr_i    : r_addr;
    assign w_cur_byte_en = (WAIT_CYCLES == 0) ? data_mem_byte_en_i : r_byte_en;
    assign w_cur_wr      = (WAIT_CYCLES == 0) ? data_mem_wr_i      : r_wr;
    assign w_cur_wr_data = (WAIT_CYCLES == 0) ? data_mem_wr_data_i : r_wr_data;

    assign w_off      = w_cur_addr - BASE_ADDR;
    assign w_in_range = (w_cur_addr >= BASE_ADDR) && ({1'b0, w_off} < LP_SPAN);
    assign w_lane     = w_cur_addr[1:0];
    assign w_idx      = w_off[LP_IDX_W+1:2];

    // Size decode: alignment check, lane mask and lane-replicated write data
    always_comb begin
        w_size_err  = 1'b0;
        w_lane_mask = 4'b0000;
        w_wr_word   = 32'd0;
        case (w_cur_byte_en)
            2'b00: begin
                w_lane_mask = 4'b0001 << w_lane;
                w_wr_word   = {4{w_cur_wr_data[7:0]}};
            end
            2'b01: begin
                w_size_err  = w_lane[0];
                w_lane_mask = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_word   = {2{w_cur_wr_data[15:0]}};
            end
            2'b11: begin
                w_size_err  = (w_lane != 2'b00);
                w_lane_mask = 4'b1111;
                w_wr_word   = w_cur_wr_data;
            end
            default: w_size_err = 1'b1;
        endcase
    end

    assign w_err      = !w_in_range || w_size_err;
    assign w_rd_shift = r_mem[w_idx] >> {w_lane, 3'b000};

    // Right-justify the addressed lanes, upper bits zero
    always_comb begin
        w_rd_val = w_rd_shift;
        case (w_cur_byte_en)
            2'b00:   w_rd_val = {24'd0, w_rd_shift[7:0]};
            2'b01:   w_rd_val = {16'd0, w_rd_shift[15:0]};
            default: w_rd_val = w_rd_shift;
        endcase
    end

    // Reset in the same cycle drops the access, so a pending write never lands
    assign w_mem_we = w_enter_resp && w_cur_wr && !w_err && !reset;

`ifdef YARP_DMEM_ZERO_INIT_EN
    localparam logic [LP_IDX_W-1:0] LP_LAST_IDX  = LP_IDX_W'(MEM_DEPTH_WORDS - 1);
    localparam state_t              LP_RST_STATE = S_CLEAR;
    logic [LP_IDX_W-1:0] r_clr_idx;

    // Clear pointer restarts at word 0 on every reset
    always_ff @(posedge clk) begin
        if (reset)
            r_clr_idx <= '0;
        else if (r_state == S_CLEAR)
            r_clr_idx <= r_clr_idx + 1'b1;
    end

    assign w_clr_we   = (r_state == S_CLEAR) && !reset;
    assign w_clr_idx  = r_clr_idx;
    assign w_clr_done = (r_clr_idx == LP_LAST_IDX);
`else
    localparam state_t LP_RST_STATE = S_IDLE;
    assign w_clr_we   = 1'b0;
    assign w_clr_idx  = '0;
    assign w_clr_done = 1'b1;
`endif

    // Array: clear writes take priority, otherwise lane-masked access writes
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= 32'd0;
        end else if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_mask[i])
                    r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= LP_RST_STATE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (data_mem_req_i) w_state_nxt = LP_ACC_STATE;
            S_WAIT:  if (r_wait_cnt == 3'd0) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = data_mem_req_i ? LP_ACC_STATE : S_IDLE;
            S_CLEAR: if (w_clr_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, wait-state counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= 32'd0;
            r_byte_en  <= 2'b00;
            r_wr       <= 1'b0;
            r_wr_data  <= 32'd0;
            r_wait_cnt <= 3'd0;
            r_rd_data  <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= data_mem_addr_i;
                r_byte_en  <= data_mem_byte_en_i;
                r_wr       <= data_mem_wr_i;
                r_wr_data  <= data_mem_wr_data_i;
                r_wait_cnt <= LP_WAIT_LOAD;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (w_enter_resp) begin
                r_err     <= w_err;
                r_rd_data <= (w_err || w_cur_wr) ? 32'd0 : w_rd_val;
            end
        end
    end

    // Outputs decoded from state; error only qualified while in RESP
    always_comb begin
        data_mem_rsp_valid_o = (r_state == S_RESP);
        data_mem_busy_o      = (r_state == S_WAIT) || (r_state == S_CLEAR);
        data_mem_err_o       = (r_state == S_RESP) && r_err;
        data_mem_rd_data_o   = r_rd_data;
    end

endmodule

// File: tb/tb_yarp_data_mem_resp.sv
// Bench for yarp_data_mem_resp: instance 0 uses WAIT_CYCLES=1, instance 1
// uses WAIT_CYCLES=0. Expected data comes from a byte-level memory model.
module tb_yarp_data_mem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_2000;
`ifdef YARP_DMEM_ZERO_INIT_EN
    localparam bit ZI = 1'b1;
`else
    localparam bit ZI = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        req [2];
    logic [31:0] addr [2];
    logic [1:0]  be [2];
    logic        wr [2];
    logic [31:0] wd [2];

    wire [31:0] rd_a, rd_b;
    wire        v_a, v_b, b_a, b_b, e_a, e_b;

    logic [31:0] rd_data [2];
    logic        rsp_valid [2];
    logic        busy [2];
    logic        err_o [2];

    always_comb begin
        rd_data[0] = rd_a;  rd_data[1] = rd_b;
        rsp_valid[0] = v_a; rsp_valid[1] = v_b;
        busy[0] = b_a;      busy[1] = b_b;
        err_o[0] = e_a;     err_o[1] = e_b;
    end

    yarp_data_mem_resp #(.MEM_DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(rst[0]), .data_mem_req_i(req[0]), .data_mem_addr_i(addr[0]),
        .data_mem_byte_en_i(be[0]), .data_mem_wr_i(wr[0]), .data_mem_wr_data_i(wd[0]),
        .data_mem_rd_data_o(rd_a), .data_mem_rsp_valid_o(v_a), .data_mem_busy_o(b_a),
        .data_mem_err_o(e_a));

    yarp_data_mem_resp #(.MEM_DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(rst[1]), .data_mem_req_i(req[1]), .data_mem_addr_i(addr[1]),
        .data_mem_byte_en_i(be[1]), .data_mem_wr_i(wr[1]), .data_mem_wr_data_i(wd[1]),
        .data_mem_rd_data_o(rd_b), .data_mem_rsp_valid_o(v_b), .data_mem_busy_o(b_b),
        .data_mem_err_o(e_b));

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [2][DEPTH];

    function automatic int wc(input int sel);
        return (sel == 0) ? 1 : 0;
    endfunction

    // Reference: size in bytes, alignment by modulo, range by byte arithmetic
    task automatic model_acc(input int sel, input logic [31:0] a, input logic [1:0] bsel,
                             input logic w, input logic [31:0] d,
                             output logic [31:0] rd, output logic er);
        int size;
        int idx;
        int off;
        size = (bsel == 2'b00) ? 1 : (bsel == 2'b01) ? 2 : (bsel == 2'b11) ? 4 : 0;
        er = 1'b0;
        rd = 32'd0;
        if (size == 0) er = 1'b1;
        else if ((a % 32'(size)) != 0) er = 1'b1;
        if ((a < BASE) || ({1'b0, a} >= ({1'b0, BASE} + 33'(4 * DEPTH)))) er = 1'b1;
        if (!er) begin
            idx = int'((a - BASE) / 32'd4);
            off = int'(a % 32'd4);
            for (int b = 0; b < size; b++) begin
                if (w) m_mem[sel][idx][8*(off+b) +: 8] = d[8*b +: 8];
                else   rd[8*b +: 8] = m_mem[sel][idx][8*(off+b) +: 8];
            end
        end
    endtask

    task automatic model_zero(input int sel);
        for (int i = 0; i < DEPTH; i++) m_mem[sel][i] = 32'd0;
    endtask

    // One access from idle: returns response data, error, latency and busy cycles
    task automatic do_txn(input int sel, input logic [31:0] a, input logic [1:0] bsel,
                          input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat, output int nb);
        @(negedge clk);
        req[sel] = 1'b1; addr[sel] = a; be[sel] = bsel; wr[sel] = w; wd[sel] = d;
        @(posedge clk);
        #1;
        req[sel] = 1'b0;
        lat = -1; nb = 0; rd = 32'd0; er = 1'b0;
        for (int k = 1; k <= 16 && lat < 0; k++) begin
            @(negedge clk);
            if (busy[sel]) nb++;
            if (rsp_valid[sel]) begin
                lat = k; rd = rd_data[sel]; er = err_o[sel];
            end
        end
    endtask

    task automatic test_reset();
        int cnt [2];
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; req[s] = 1'b0; addr[s] = 32'd0; be[s] = 2'b00; wr[s] = 1'b0; wd[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_tests++; if (rd_data[s] !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data[%0d]: got %h exp 0", s, rd_data[s]); end
            n_tests++; if (rsp_valid[s] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b exp 0", s, rsp_valid[s]); end
            n_tests++; if (err_o[s] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b exp 0", s, err_o[s]); end
            n_tests++; if (busy[s] !== ZI) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b exp %b", s, busy[s], ZI); end
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        cnt[0] = 0; cnt[1] = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy[0]) cnt[0]++;
            if (busy[1]) cnt[1]++;
            if (!busy[0] && !busy[1]) break;
        end
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if (cnt[s] !== (ZI ? DEPTH : 0)) begin
                n_fail++; $display("FAIL post_reset_busy_cycles[%0d]: got %0d exp %0d", s, cnt[s], ZI ? DEPTH : 0);
            end
            if (ZI) model_zero(s);
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd, mrd; logic er, mer; int lat, nb;
        model_acc(0, 32'h2004, 2'b11, 1'b1, 32'hDEAD_BEEF, mrd, mer);
        do_txn(0, 32'h2004, 2'b11, 1'b1, 32'hDEAD_BEEF, rd, er, lat, nb);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL word_wr_latency: got %0d exp 2", lat); end
        n_tests++; if (nb !== 1) begin n_fail++; $display("FAIL word_wr_busy_cycles: got %0d exp 1", nb); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL word_wr_err: got %b exp 0", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL word_wr_rd_data: got %h exp 0", rd); end
        model_acc(0, 32'h2004, 2'b11, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2004, 2'b11, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_rd_data: got %h exp deadbeef", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL word_rd_err: got %b exp 0", er); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd, mrd; logic er, mer; int lat, nb;
        model_acc(0, 32'h2005, 2'b00, 1'b1, 32'h0000_00AA, mrd, mer);
        do_txn(0, 32'h2005, 2'b00, 1'b1, 32'h0000_00AA, rd, er, lat, nb);
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL byte_wr_err: got %b exp 0", er); end
        model_acc(0, 32'h2004, 2'b11, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2004, 2'b11, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL byte_merge_rd: got %h exp deadaaef", rd); end
        @(negedge clk);
        n_tests++; if (rd_data[0] !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL rd_data_hold: got %h exp deadaaef", rd_data[0]); end
        n_tests++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rsp_valid_single_cycle: got %b exp 0", rsp_valid[0]); end
        model_acc(0, 32'h2007, 2'b00, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2007, 2'b00, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== 32'h0000_00DE) begin n_fail++; $display("FAIL byte_rd: got %h exp 000000de", rd); end
        model_acc(0, 32'h2006, 2'b01, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2006, 2'b01, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== 32'h0000_DEAD) begin n_fail++; $display("FAIL half_rd: got %h exp 0000dead", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL half_rd_err: got %b exp 0", er); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd; logic er, mer; int lat, nb;
        logic [31:0] ea [6];
        logic [1:0]  eb [6];
        logic        ew [6];
        ea = '{32'h2005, 32'h2006, 32'h2004, 32'h1FFC, 32'h3000, 32'h2005};
        eb = '{2'b01,    2'b11,    2'b10,    2'b11,    2'b11,    2'b01};
        ew = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1};
        for (int i = 0; i < 6; i++) begin
            model_acc(0, ea[i], eb[i], ew[i], 32'h0000_FFFF, mrd, mer);
            do_txn(0, ea[i], eb[i], ew[i], 32'h0000_FFFF, rd, er, lat, nb);
            n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_case%0d_err: addr %h got %b exp 1", i, ea[i], er); end
            n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL err_case%0d_rd: addr %h got %h exp 0", i, ea[i], rd); end
        end
        @(negedge clk);
        n_tests++; if (err_o[0] !== 1'b0) begin n_fail++; $display("FAIL err_outside_resp: got %b exp 0", err_o[0]); end
        model_acc(0, 32'h2004, 2'b11, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2004, 2'b11, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL err_write_blocked: got %h exp deadaaef", rd); end
    endtask

    task automatic test_no_alias();
        logic [31:0] rd, mrd; logic er, mer; int lat, nb;
        model_acc(0, 32'h2000, 2'b11, 1'b1, 32'hA5A5_0001, mrd, mer);
        do_txn(0, 32'h2000, 2'b11, 1'b1, 32'hA5A5_0001, rd, er, lat, nb);
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL alias_setup_err: got %b exp 0", er); end
        model_acc(0, 32'h3000, 2'b11, 1'b1, 32'h1234_5678, mrd, mer);
        do_txn(0, 32'h3000, 2'b11, 1'b1, 32'h1234_5678, rd, er, lat, nb);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL alias_wr_err: got %b exp 1", er); end
        model_acc(0, 32'h2000, 2'b11, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2000, 2'b11, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL no_alias_rd: got %h exp a5a50001", rd); end
    endtask

    task automatic test_back_to_back(input int sel);
        logic [31:0] rd, mrd; logic er, mer; int lat, nb;
        logic [31:0] ba [3];
        logic [31:0] bd [3];
        int w;
        int nacc;
        int k;
        logic exp_v, exp_b;
        w = wc(sel);
        for (int j = 0; j < 3; j++) begin
            ba[j] = 32'h2010 + 32'(4 * j);
            bd[j] = $urandom;
            model_acc(sel, ba[j], 2'b11, 1'b1, bd[j], mrd, mer);
            do_txn(sel, ba[j], 2'b11, 1'b1, bd[j], rd, er, lat, nb);
            n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL b2b_setup_err[%0d]: got %b exp 0", sel, er); end
        end
        @(negedge clk);
        req[sel] = 1'b1; addr[sel] = ba[0]; be[sel] = 2'b11; wr[sel] = 1'b0; wd[sel] = 32'd0;
        nacc = 0;
        for (int e = 0; e < 3 * (w + 1) + 1; e++) begin
            @(posedge clk);
            #1;
            if ((e % (w + 1)) == 0 && nacc < 3) begin
                nacc++;
                if (nacc < 3) addr[sel] = ba[nacc];
                else req[sel] = 1'b0;
            end
            @(negedge clk);
            k = e + 1;
            exp_v = ((k % (w + 1)) == 0) && (k <= 3 * (w + 1));
            exp_b = (w > 0) && ((k % (w + 1)) != 0) && (k < 3 * (w + 1));
            n_tests++; if (rsp_valid[sel] !== exp_v) begin n_fail++; $display("FAIL b2b_valid[%0d] cyc %0d: got %b exp %b", sel, k, rsp_valid[sel], exp_v); end
            n_tests++; if (busy[sel] !== exp_b) begin n_fail++; $display("FAIL b2b_busy[%0d] cyc %0d: got %b exp %b", sel, k, busy[sel], exp_b); end
            if (exp_v) begin
                n_tests++;
                if (rd_data[sel] !== bd[k / (w + 1) - 1]) begin
                    n_fail++; $display("FAIL b2b_rd[%0d] cyc %0d: got %h exp %h", sel, k, rd_data[sel], bd[k / (w + 1) - 1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, mrd; logic er, mer; int lat, nb;
        int cnt;
        logic saw_v;
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 32'h2004; be[0] = 2'b11; wr[0] = 1'b1; wd[0] = 32'h5555_5555;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        cnt = 0; saw_v = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) saw_v = 1'b1;
            if (busy[0]) cnt++;
            if (!busy[0] && k >= 4) break;
        end
        n_tests++; if (saw_v !== 1'b0) begin n_fail++; $display("FAIL mid_wait_reset_rsp: got %b exp 0", saw_v); end
        n_tests++; if (cnt !== (ZI ? DEPTH : 0)) begin n_fail++; $display("FAIL mid_wait_busy_cycles: got %0d exp %0d", cnt, ZI ? DEPTH : 0); end
        if (ZI) model_zero(0);
        model_acc(0, 32'h2004, 2'b11, 1'b0, 32'd0, mrd, mer);
        do_txn(0, 32'h2004, 2'b11, 1'b0, 32'd0, rd, er, lat, nb);
        n_tests++; if (rd !== (ZI ? 32'd0 : 32'hDEAD_AAEF)) begin n_fail++; $display("FAIL mid_wait_not_committed: got %h exp %h", rd, ZI ? 32'd0 : 32'hDEAD_AAEF); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL mid_wait_next_latency: got %0d exp 2", lat); end
    endtask

    task automatic test_random(input int sel);
        logic [31:0] rd, mrd, a, d; logic er, mer, w; logic [1:0] bsel; int lat, nb, r;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_acc(sel, BASE + 32'(4 * i), 2'b11, 1'b1, d, mrd, mer);
            do_txn(sel, BASE + 32'(4 * i), 2'b11, 1'b1, d, rd, er, lat, nb);
            n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL rnd_fill_err[%0d] word %0d: got %b exp 0", sel, i, er); end
        end
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'h1FFC + 32'($urandom_range(0, 3));
            else if (r == 1) a = 32'h3000 + 32'($urandom_range(0, 7));
            else             a = 32'h2000 + 32'($urandom_range(0, 63));
            bsel = 2'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            d    = $urandom;
            model_acc(sel, a, bsel, w, d, mrd, mer);
            do_txn(sel, a, bsel, w, d, rd, er, lat, nb);
            n_tests++; if (rd !== mrd) begin n_fail++; $display("FAIL rnd_rd[%0d] a=%h be=%b wr=%b: got %h exp %h", sel, a, bsel, w, rd, mrd); end
            n_tests++; if (er !== mer) begin n_fail++; $display("FAIL rnd_err[%0d] a=%h be=%b wr=%b: got %b exp %b", sel, a, bsel, w, er, mer); end
            n_tests++; if (lat !== wc(sel) + 1) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", sel, lat, wc(sel) + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_errors();
        test_no_alias();
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid_wait();
        test_random(0);
        test_random(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
